// File: rtl/imem_access_ctrl.sv
// Instruction-memory arbiter: shares one synchronous-read RAM between fetch and a byte-serial loader.
// Latency: fetch read data returns one cycle after the address; a loaded word is written one cycle after its last byte.
// Backpressure: the loader is throttled by ld_byte_ready_o (low outside LOAD); fetch holds its address under stall.
module imem_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] fetch_pc_i,
  input  logic              fetch_stall_i,
  output logic [DATA_W-1:0] fetch_inst_o,
  output logic              fetch_valid_o,
  output logic              cpu_run_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_byte_valid_i,
  output logic              ld_byte_ready_o,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = $clog2(BYTES);
  // Largest legal load length: the whole memory.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   held_addr_q, held_addr_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                cpu_run_q, cpu_run_d;
  logic                ld_busy_q, ld_busy_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;

  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W:0]     word_cnt_inc;

  // Stalled fetch re-reads the previous address so the returned word stays stable.
  assign rd_addr      = fetch_stall_i ? held_addr_q : fetch_pc_i;
  // Address arithmetic is naturally modulo the memory depth.
  assign wr_addr      = base_q + word_cnt_q[ADDR_W-1:0];
  assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);

  assign fetch_inst_o  = fetch_valid_q ? mem_rdata_i : NOP_WORD;
  assign fetch_valid_o = fetch_valid_q;
  assign cpu_run_o     = cpu_run_q;
  assign ld_busy_o     = ld_busy_q;

  // State and datapath registers; reset drops any partially assembled word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_RUN;
      held_addr_q   <= '0;
      fetch_valid_q <= 1'b0;
      cpu_run_q     <= 1'b1;
      ld_busy_q     <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      word_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
    end else begin
      state_q       <= state_d;
      held_addr_q   <= held_addr_d;
      fetch_valid_q <= fetch_valid_d;
      cpu_run_q     <= cpu_run_d;
      ld_busy_q     <= ld_busy_d;
      base_q        <= base_d;
      len_q         <= len_d;
      word_cnt_q    <= word_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
    end
  end

  // Next-state and memory-port control for the run/load sequencer.
  always_comb begin
    state_d         = state_q;
    held_addr_d     = held_addr_q;
    fetch_valid_d   = fetch_valid_q;
    cpu_run_d       = cpu_run_q;
    ld_busy_d       = ld_busy_q;
    base_d          = base_q;
    len_d           = len_q;
    word_cnt_d      = word_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    asm_d           = asm_q;
    mem_addr_o      = held_addr_q;
    mem_we_o        = 1'b0;
    mem_wdata_o     = '0;
    ld_byte_ready_o = 1'b0;
    ld_done_o       = 1'b0;

    case (state_q)
      ST_RUN: begin
        mem_addr_o    = rd_addr;
        held_addr_d   = rd_addr;
        fetch_valid_d = 1'b1;
        // A load request takes priority over any stall; the pipeline is frozen anyway.
        if (ld_start_i) begin
          base_d        = ld_base_i;
          len_d         = (ld_len_i > MAX_LEN) ? MAX_LEN : ld_len_i;
          word_cnt_d    = '0;
          byte_cnt_d    = '0;
          cpu_run_d     = 1'b0;
          fetch_valid_d = 1'b0;
          ld_busy_d     = 1'b1;
          state_d       = (ld_len_i == '0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld_byte_ready_o = 1'b1;
        fetch_valid_d   = 1'b0;
        if (ld_byte_valid_i) begin
          // Little-endian assembly: the first byte ends up in the low lane.
          asm_d      = {ld_byte_i, asm_q[DATA_W-1:8]};
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          if (byte_cnt_q == BC_W'(BYTES - 1)) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        mem_addr_o    = wr_addr;
        mem_we_o      = 1'b1;
        mem_wdata_o   = asm_q;
        fetch_valid_d = 1'b0;
        word_cnt_d    = word_cnt_inc;
        byte_cnt_d    = '0;
        state_d       = (word_cnt_inc == len_q) ? ST_DONE : ST_LOAD;
      end

      ST_DONE: begin
        ld_done_o     = 1'b1;
        fetch_valid_d = 1'b0;
        ld_busy_d     = 1'b0;
        cpu_run_d     = 1'b1;
        state_d       = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: behavioural RAM plus a word-level model of memory contents and fetch.
// Latency: fetch data expected one cycle after the read address; words land at base+index modulo 2048.
// Backpressure: byte valid is randomised; bytes count as taken only when valid and ready coincide.
module tb_imem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] fetch_pc;
  logic        fetch_stall;
  logic [31:0] fetch_inst;
  logic        fetch_valid;
  logic        cpu_run;
  logic        ld_start;
  logic [10:0] ld_base;
  logic [11:0] ld_len;
  logic [7:0]  ld_byte;
  logic        ld_byte_valid;
  logic        ld_byte_ready;
  logic        ld_busy;
  logic        ld_done;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  // Memory array behind the DUT; unwritten words read a seeded background pattern.
  logic [31:0] mem_arr [0:2047];
  bit          written [0:2047];
  logic [31:0] rd_tmp;
  logic [31:0] seed;

  // Reference: expected contents of every word and the last address fetch read.
  logic [31:0] exp_mem [0:2047];
  logic [10:0] last_addr;
  logic [31:0] dir_words [$];

  always #5 clock = ~clock;

  imem_access_ctrl dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .fetch_pc_i      (fetch_pc),
    .fetch_stall_i   (fetch_stall),
    .fetch_inst_o    (fetch_inst),
    .fetch_valid_o   (fetch_valid),
    .cpu_run_o       (cpu_run),
    .ld_start_i      (ld_start),
    .ld_base_i       (ld_base),
    .ld_len_i        (ld_len),
    .ld_byte_i       (ld_byte),
    .ld_byte_valid_i (ld_byte_valid),
    .ld_byte_ready_o (ld_byte_ready),
    .ld_busy_o       (ld_busy),
    .ld_done_o       (ld_done),
    .mem_addr_o      (mem_addr),
    .mem_we_o        (mem_we),
    .mem_wdata_o     (mem_wdata),
    .mem_rdata_i     (mem_rdata)
  );

  function automatic logic [31:0] bg(input logic [10:0] a);
    return ({21'h0, a} * 32'h9E37_79B1) ^ seed;
  endfunction

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clock) begin
    rd_tmp = written[mem_addr] ? mem_arr[mem_addr] : bg(mem_addr);
    if (mem_we) begin
      mem_arr[mem_addr] = mem_wdata;
      written[mem_addr] = 1'b1;
    end
    mem_rdata <= rd_tmp;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One RUN cycle: check the read address, then the returned instruction.
  task automatic fetch_step(input logic [10:0] pc, input logic stall);
    logic [10:0] a;
    fetch_pc    = pc;
    fetch_stall = stall;
    #1;
    a = stall ? last_addr : pc;
    check("fetch_addr", {21'h0, mem_addr}, {21'h0, a});
    check("fetch_no_we", {31'h0, mem_we}, 32'h0);
    tick();
    last_addr = a;
    check("fetch_valid", {31'h0, fetch_valid}, 32'h1);
    check("fetch_inst", fetch_inst, exp_mem[a]);
  endtask

  // Full load transaction; abort_after>0 asserts reset once that many bytes are taken.
  task automatic do_load(input logic [10:0] base, input logic [11:0] len,
                         input int vpct, input int abort_after);
    int          n;
    int          accepted;
    int          writes;
    int          cyc;
    int          bound;
    bit          done_seen;
    logic [31:0] words [$];
    logic [31:0] w;
    logic [10:0] pc;
    logic        st;

    n = (len > 12'd2048) ? 2048 : int'(len);
    for (int i = 0; i < n; i++) begin
      if (dir_words.size() > 0) w = dir_words.pop_front();
      else w = $urandom;
      words.push_back(w);
    end

    pc          = 11'($urandom);
    st          = 1'($urandom);
    fetch_pc    = pc;
    fetch_stall = st;
    ld_start    = 1'b1;
    ld_base     = base;
    ld_len      = len;
    #1;
    check("start_no_we", {31'h0, mem_we}, 32'h0);
    tick();
    if (!st) last_addr = pc;
    ld_start = 1'b0;
    check("start_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("start_busy", {31'h0, ld_busy}, 32'h1);
    check("start_valid", {31'h0, fetch_valid}, 32'h0);

    accepted  = 0;
    writes    = 0;
    cyc       = 0;
    done_seen = 1'b0;
    bound     = n * 40 + 40;
    while (!done_seen && cyc < bound) begin
      ld_byte_valid = ($urandom_range(99) < vpct);
      if (accepted < 4 * n) ld_byte = 8'(words[accepted / 4] >> (8 * (accepted % 4)));
      else ld_byte = 8'($urandom);
      // Noise on the start/stall/pc inputs must have no effect while loading.
      ld_start    = 1'($urandom);
      ld_base     = 11'($urandom);
      ld_len      = 12'($urandom);
      fetch_stall = 1'($urandom);
      fetch_pc    = 11'($urandom);
      #1;
      check("load_cpu_run", {31'h0, cpu_run}, 32'h0);
      check("load_inst_nop", fetch_inst, 32'h0);
      if (mem_we) begin
        check("write_in_range", {31'h0, writes < n}, 32'h1);
        check("write_ready_low", {31'h0, ld_byte_ready}, 32'h0);
        check("write_after_bytes", accepted, 4 * (writes + 1));
        if (writes < n) begin
          check("write_addr", {21'h0, mem_addr}, {21'h0, 11'(base + 11'(writes))});
          check("write_data", mem_wdata, words[writes]);
        end
        writes++;
      end
      if (ld_done) begin
        done_seen = 1'b1;
        check("done_word_count", writes, n);
        check("done_no_we", {31'h0, mem_we}, 32'h0);
        if (vpct == 100) check("done_cycle", cyc, 5 * n);
      end
      if (ld_byte_ready && ld_byte_valid) accepted++;
      tick();
      cyc++;
      if (abort_after > 0 && accepted == abort_after) begin
        reset         = 1'b1;
        ld_byte_valid = 1'b0;
        ld_start      = 1'b0;
        fetch_stall   = 1'b0;
        tick();
        check("abort_cpu_run", {31'h0, cpu_run}, 32'h1);
        check("abort_busy", {31'h0, ld_busy}, 32'h0);
        check("abort_ready", {31'h0, ld_byte_ready}, 32'h0);
        check("abort_valid", {31'h0, fetch_valid}, 32'h0);
        check("abort_done", {31'h0, ld_done}, 32'h0);
        check("abort_we", {31'h0, mem_we}, 32'h0);
        check("abort_writes", writes, abort_after / 4);
        reset = 1'b0;
        for (int i = 0; i < abort_after / 4; i++) exp_mem[11'(base + 11'(i))] = words[i];
        last_addr = '0;
        return;
      end
    end
    if (!done_seen) check("load_timeout", 32'h0, 32'h1);

    ld_start      = 1'b0;
    ld_byte_valid = 1'b0;
    fetch_stall   = 1'b0;
    check("post_done_pulse", {31'h0, ld_done}, 32'h0);
    check("post_busy", {31'h0, ld_busy}, 32'h0);
    check("post_cpu_run", {31'h0, cpu_run}, 32'h1);
    check("post_valid", {31'h0, fetch_valid}, 32'h0);
    check("post_ready", {31'h0, ld_byte_ready}, 32'h0);
    for (int i = 0; i < n; i++) exp_mem[11'(base + 11'(i))] = words[i];
  endtask

  initial begin
    reset         = 1'b1;
    fetch_pc      = '0;
    fetch_stall   = 1'b0;
    ld_start      = 1'b0;
    ld_base       = '0;
    ld_len        = '0;
    ld_byte       = '0;
    ld_byte_valid = 1'b0;
    seed          = $urandom;
    for (int i = 0; i < 2048; i++) exp_mem[i] = bg(11'(i));
    last_addr = '0;

    tick();
    tick();
    check("rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_inst", fetch_inst, 32'h0);
    check("rst_cpu_run", {31'h0, cpu_run}, 32'h1);
    check("rst_ready", {31'h0, ld_byte_ready}, 32'h0);
    check("rst_busy", {31'h0, ld_busy}, 32'h0);
    check("rst_done", {31'h0, ld_done}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr", {21'h0, mem_addr}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    // Sequential fetch, then a three-cycle stall while PC moves on.
    fetch_step(11'd0, 1'b0);
    fetch_step(11'd1, 1'b0);
    fetch_step(11'd2, 1'b0);
    fetch_step(11'd5, 1'b0);
    for (int i = 0; i < 3; i++) fetch_step(11'd6, 1'b1);
    fetch_step(11'd6, 1'b0);
    fetch_step(11'd7, 1'b0);

    for (int i = 0; i < 40; i++) fetch_step(11'($urandom), $urandom_range(99) < 30);

    // Directed two-word load with known byte stream.
    dir_words.push_back(32'h8765_4321);
    dir_words.push_back(32'hDEAD_BEEF);
    do_load(11'd16, 12'd2, 100, 0);
    fetch_step(11'd16, 1'b0);
    fetch_step(11'd17, 1'b0);
    check("load16_value", exp_mem[16], 32'h8765_4321);
    check("load17_value", exp_mem[17], 32'hDEAD_BEEF);

    // Wrap past the top of memory.
    do_load(11'd2047, 12'd2, 100, 0);
    fetch_step(11'd2047, 1'b0);
    fetch_step(11'd0, 1'b0);

    // Zero-length load: straight to done, nothing written.
    do_load(11'd5, 12'd0, 100, 0);
    fetch_step(11'd5, 1'b0);

    // Randomly throttled byte stream.
    begin
      logic [10:0] b;
      b = 11'($urandom);
      do_load(b, 12'd5, 50, 0);
      for (int i = 0; i < 5; i++) fetch_step(11'(b + 11'(i)), 1'b0);
    end

    // Over-long request is clamped to the full memory.
    do_load(11'($urandom), 12'd3072, 100, 0);
    for (int i = 0; i < 4; i++) fetch_step(11'($urandom), 1'b0);

    // Reset after six bytes of a two-word load.
    do_load(11'd100, 12'd2, 100, 6);
    fetch_step(11'd100, 1'b0);
    fetch_step(11'd101, 1'b0);
    fetch_step(11'd102, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Controls the single-port 2048x32 instruction memory and shares it between two requesters: the pipeline fetch stage and a byte-serial program loader.
- The loader (fed by a debug/UART receiver) assembles 32-bit words and writes them into memory while the CPU is held.
- The fetch path issues synchronous reads and honours hazard-unit stalls.
- Sits between the PC/IF stage, the hazard detection unit, the loader front end and the instruction memory array.

Parameters:
ADDR_W, 11, memory word-address width (2048 words)
DATA_W, 32, instruction width
NOP_WORD, 32'h0000_0000, value presented on fetch_inst when no valid instruction

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
fetch_pc  in  ADDR_W  word address from PC
fetch_stall  in  1  hazard unit stall; hold current instruction
fetch_inst  out  DATA_W  instruction to IF/ID
fetch_valid  out  1  fetch_inst holds a real memory word
cpu_run  out  1  pipeline may advance; low while loading
ld_start  in  1  begin a load; sampled in RUN only
ld_base  in  ADDR_W  first word address of load; sampled with ld_start
ld_len  in  ADDR_W+1  number of words; sampled with ld_start
ld_byte  in  8  loader data byte
ld_byte_valid  in  1  ld_byte valid
ld_byte_ready  out  1  controller accepts byte
ld_busy  out  1  load in progress
ld_done  out  1  one-cycle pulse at end of load
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency

Behaviour:
- Reset values:
  - state=RUN; fetch_valid=0; fetch_inst=NOP_WORD; cpu_run=1.
  - ld_byte_ready=0; ld_busy=0; ld_done=0.
  - mem_we=0; mem_addr=0; mem_wdata=0.
  - Byte counter, word counter and held address all 0.
- States: RUN, LOAD, WRITE, DONE.
- RUN:
  - mem_we=0; mem_addr = fetch_stall ? held_addr : fetch_pc.
  - held_addr <= mem_addr every cycle.
  - fetch_valid <= 1 in the cycle after any RUN-state read.
  - fetch_inst = fetch_valid ? mem_rdata : NOP_WORD.
  - Under stall, the same address is re-read, so fetch_inst is stable for the whole stall.
- RUN -> LOAD on ld_start=1:
  - Latch ld_base and ld_len; clamp len >2048 to 2048.
  - If len==0: go to DONE directly, no writes.
  - cpu_run<=0; fetch_valid<=0; ld_busy<=1.
- LOAD:
  - ld_byte_ready=1.
  - On ld_byte_valid&&ld_byte_ready, shift byte into assembly register, little-endian (first byte -> bits 7:0, fourth -> 31:24); byte counter +1.
  - On acceptance of the 4th byte, go to WRITE.
  - ld_start is ignored.
- WRITE (exactly 1 cycle):
  - ld_byte_ready=0; mem_we=1; mem_addr=(base+word_cnt) mod 2048; mem_wdata=assembled word.
  - word_cnt+1, byte counter reset to 0.
  - If word_cnt+1==len, go to DONE; otherwise go to LOAD.
- DONE (1 cycle):
  - ld_done=1; ld_busy<=0; cpu_run<=1; go to RUN.
  - fetch_valid stays 0 until the first RUN read returns (2 cycles after DONE).
- Address wrap: base+count wraps modulo 2048 (base 2047, len 2 writes 2047 then 0).
- Throughput: one word per 5 cycles minimum (4 byte accepts + WRITE).
- Simultaneous ld_start and fetch_stall in RUN: load wins; the stall is irrelevant once cpu_run=0.
- Reset mid-load: return to RUN with reset values. Already-written words remain in memory; partial bytes are discarded.
- mem_we is never asserted outside WRITE.

Test Plan:
- Reset, then fetch_pc=0,1,2 on successive cycles (mem[0..2]=A,B,C) -> fetch_valid=1 from cycle 2; fetch_inst=A,B,C with 1-cycle latency.
- fetch_pc=5 and fetch_stall=1 for 3 cycles while PC changes to 6 -> mem_addr held at 5; fetch_inst=mem[5] for all 3 cycles; mem[6] appears 1 cycle after stall drops.
- ld_start, ld_base=16, ld_len=2, bytes 21,43,65,87,EF,BE,AD,DE -> mem[16]=87654321, mem[17]=DEADBEEF; cpu_run=0 throughout; ld_done pulses once; RUN resumes.
- ld_base=2047, ld_len=2, 8 bytes -> writes at addresses 2047 then 0; ld_len=0 -> ld_done the cycle after start, mem_we never asserted.
- ld_byte_valid toggled randomly during load -> bytes accepted only when valid&&ready; ld_byte_ready=0 during WRITE; word values unchanged.
- Reset asserted after 6 bytes of a 2-word load -> first word written, second not; state RUN; ld_busy=0; cpu_run=1; fetch_valid=0 for one cycle.
